zube_sched: RTL and testbench
=============================

ZUBE_SCHED -- requirements
Module: zube_sched

Interface
REQ-001 BASE_ADDRESS, default 32'h3000_0000: mailbox base; DATA = base+4, CONTROL = base+8, STATUS = base+12.
REQ-002 POLL_CYCLES, default 1000: idle cycles between unsolicited status polls.
REQ-003 TIMEOUT_CYCLES, default 64: maximum cycles to wait for wbm_ack_in.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_b  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  scheduler run enable.
REQ-007 zube_irq  in  1  mailbox activity pulse.
REQ-008 wbm_cyc_out / wbm_stb_out  out  1 each  Wishbone master cycle/strobe, always driven equal.
REQ-009 wbm_we_out  out  1  write enable.
REQ-010 wbm_addr_out  out  32  transaction address.
REQ-011 wbm_data_out  out  32  write data, {24'b0, byte}.
REQ-012 wbm_data_in  in  32  read data; only [7:0] used.
REQ-013 wbm_ack_in  in  1  slave acknowledge.
REQ-014 rx_valid / rx_data / rx_ctrl  out  1/8/1  received byte; rx_ctrl=1 if from CONTROL.
REQ-015 rx_ready  in  1  downstream accepts rx byte.
REQ-016 tx_valid / tx_data / tx_ctrl  in  1/8/1  byte to send; tx_ctrl=1 selects CONTROL.
REQ-017 tx_ready  out  1  one-cycle pulse: tx byte consumed.
REQ-018 bus_error  out  1  sticky timeout flag.

Function
REQ-019 States: IDLE, POLL, DECIDE, RX_READ, RX_HOLD, TX_WRITE, GAP.
REQ-020 Bus transaction: cyc=stb=1 with addr/we/data held stable until ack; read data captured on ack edge; cyc/stb low the next cycle.
REQ-021 Every transaction is followed by at least one cycle with cyc=stb=0 (GAP); the slave edge-detects strobes.
REQ-022 irq_pending sets on any cycle zube_irq=1; clears when a POLL transaction starts; a set in the same cycle wins.
REQ-023 IDLE -> POLL when enable and (irq_pending, or tx_valid, or poll counter = POLL_CYCLES-1); counter clears on entering POLL, counts only in IDLE.
REQ-024 POLL: read STATUS, latch status[7:0] = {full[3:0], ready[3:0]}; bit map: 0 Z80->ASIC data, 1 Z80->ASIC control, 2 ASIC->Z80 data, 3 ASIC->Z80 control.
REQ-025 DECIDE: rx candidate = ready[1] or ready[0]; tx candidate = tx_valid and not full[2+tx_ctrl].
REQ-026 Both candidates: alternate by last_served bit (rx first after reset); one only: serve it; none: IDLE.
REQ-027 RX_READ reads CONTROL if ready[1], else DATA; on ack drive rx_data=byte, rx_ctrl accordingly, rx_valid=1, enter RX_HOLD.
REQ-028 RX_HOLD: rx_valid/rx_data/rx_ctrl held stable, no bus activity, until rx_ready=1; then rx_valid=0 same edge, -> GAP.
REQ-029 TX_WRITE writes {24'b0, tx_data} to DATA or CONTROL per tx_ctrl; tx_ready=1 for the ack cycle only; tx_data/tx_ctrl required stable while tx_valid and not tx_ready.
REQ-030 GAP -> POLL if enable, else IDLE; status always re-read before next service.
REQ-031 enable low never aborts a started transaction or RX_HOLD; block stops at next GAP/DECIDE.
REQ-032 Timeout counter runs while cyc=1; reaching TIMEOUT_CYCLES without ack: drop cyc/stb, set bus_error, no rx_valid, no tx_ready, -> IDLE.
REQ-033 bus_error clears only on reset; operation continues after it is set.
REQ-034 An ack arriving in the same cycle as timeout expiry counts as success.

Reset
REQ-035 reset_b low asynchronously forces: state IDLE, all outputs 0, counters 0, irq_pending 0, status 0, last_served = rx-first.
REQ-036 Reset mid-transaction or mid-RX_HOLD discards it; the first transaction after release is a STATUS read.

Verification
REQ-037 Reset, enable=1, irq pulse; STATUS returns 0x01, DATA returns 0x5A: read 0x3000000C, gap, read 0x30000004, rx_valid=1 rx_data=0x5A rx_ctrl=0, then STATUS re-read.
REQ-038 STATUS 0x03: CONTROL (0x30000008) read first, rx_ctrl=1; DATA read only after re-poll.
REQ-039 tx_valid, tx_data=0xA5, tx_ctrl=0, STATUS 0x00: write 0x000000A5 to 0x30000004 we=1, tx_ready high exactly the ack cycle; STATUS 0x40: no write, re-poll after 1000 idle cycles.
REQ-040 STATUS 0x01 persistently with tx_valid held: services alternate rx, tx, rx, tx.
REQ-041 Slave never acks: cyc drops after 64 cycles, bus_error=1, tx_ready never pulses, next poll proceeds normally.
REQ-042 rx_ready low 10 cycles: rx_valid/rx_data stable, cyc=0; reset_b low during hold: rx_valid=0 immediately.

Source files
------------

// File: rtl/zube_sched.sv
// zube_sched: Wishbone mailbox scheduler. Polls the mailbox STATUS register, then
// moves one byte per service between the mailbox and the rx/tx streams.
module zube_sched #(
  parameter logic [31:0] BASE_ADDRESS   = 32'h3000_0000,
  parameter int          POLL_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        enable,
  input  logic        zube_irq,
  output logic        wbm_cyc_out,
  output logic        wbm_stb_out,
  output logic        wbm_we_out,
  output logic [31:0] wbm_addr_out,
  output logic [31:0] wbm_data_out,
  input  logic [31:0] wbm_data_in,
  input  logic        wbm_ack_in,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_ctrl,
  input  logic        rx_ready,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  input  logic        tx_ctrl,
  output logic        tx_ready,
  output logic        bus_error
);

  localparam logic [31:0] ADDR_DATA   = BASE_ADDRESS + 32'd4;
  localparam logic [31:0] ADDR_CTRL   = BASE_ADDRESS + 32'd8;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDRESS + 32'd12;

  localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_DECIDE, S_RX_READ, S_RX_HOLD, S_TX_WRITE, S_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_poll_cnt;
  logic [TW-1:0]   r_to_cnt;
  logic            r_irq_pending;
  logic            r_tx_turn;
  logic [7:0]      r_status;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_rx_valid;
  logic [7:0]      r_rx_data;
  logic            r_rx_ctrl;
  logic            r_bus_error;

  logic            w_cyc;
  logic            w_timeout;
  logic            w_tx_full;
  logic            w_rx_cand;
  logic            w_tx_cand;
  logic            w_serve_rx;
  logic            w_serve_tx;
  logic            w_poll_trig;
  logic            w_entering;
  logic            w_unused_rdata;

  assign w_cyc       = (r_state == S_POLL) || (r_state == S_RX_READ) || (r_state == S_TX_WRITE);
  assign w_timeout   = w_cyc && !wbm_ack_in && (r_to_cnt == TO_LAST);
  assign w_tx_full   = tx_ctrl ? r_status[7] : r_status[6];
  assign w_rx_cand   = r_status[1] | r_status[0];
  assign w_tx_cand   = tx_valid && !w_tx_full;
  assign w_serve_rx  = w_rx_cand && (!w_tx_cand || !r_tx_turn);
  assign w_serve_tx  = w_tx_cand && !w_serve_rx;
  assign w_entering  = (w_state_nxt != r_state);
  // A tx byte whose destination was last seen full does not force a poll; it waits
  // for an irq or the periodic poll instead of hammering STATUS.
  assign w_poll_trig = r_irq_pending || w_tx_cand || (r_poll_cnt == POLL_LAST);
  assign w_unused_rdata = ^wbm_data_in[31:8];

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (enable && w_poll_trig) w_state_nxt = S_POLL;
      S_POLL: begin
        if (wbm_ack_in)     w_state_nxt = S_DECIDE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_DECIDE: begin
        if (!enable)         w_state_nxt = S_IDLE;
        else if (w_serve_rx) w_state_nxt = S_RX_READ;
        else if (w_serve_tx) w_state_nxt = S_TX_WRITE;
        else                 w_state_nxt = S_IDLE;
      end
      S_RX_READ: begin
        if (wbm_ack_in)     w_state_nxt = S_RX_HOLD;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_RX_HOLD:  if (rx_ready) w_state_nxt = S_GAP;
      S_TX_WRITE: begin
        if (wbm_ack_in)     w_state_nxt = S_GAP;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_GAP:      w_state_nxt = enable ? S_POLL : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state       <= S_IDLE;
      r_poll_cnt    <= '0;
      r_to_cnt      <= '0;
      r_irq_pending <= 1'b0;
      r_tx_turn     <= 1'b0;
      r_status      <= '0;
      r_bus_error   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_entering && (w_state_nxt == S_POLL))
        r_poll_cnt <= '0;
      else if ((r_state == S_IDLE) && (r_poll_cnt != POLL_LAST))
        r_poll_cnt <= r_poll_cnt + 1'b1;

      if (zube_irq)
        r_irq_pending <= 1'b1;
      else if (w_entering && (w_state_nxt == S_POLL))
        r_irq_pending <= 1'b0;

      if (w_entering)
        r_to_cnt <= '0;
      else if (w_cyc)
        r_to_cnt <= r_to_cnt + 1'b1;

      if ((r_state == S_POLL) && wbm_ack_in)
        r_status <= wbm_data_in[7:0];

      if ((r_state == S_DECIDE) && enable) begin
        if (w_serve_rx)      r_tx_turn <= 1'b1;
        else if (w_serve_tx) r_tx_turn <= 1'b0;
      end

      if (w_timeout)
        r_bus_error <= 1'b1;
    end
  end

  // Bus request fields are registered on entry so they stay stable until ack.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_entering) begin
      unique case (w_state_nxt)
        S_POLL: begin
          r_we    <= 1'b0;
          r_addr  <= ADDR_STATUS;
          r_wdata <= '0;
        end
        S_RX_READ: begin
          r_we    <= 1'b0;
          r_addr  <= r_status[1] ? ADDR_CTRL : ADDR_DATA;
          r_wdata <= '0;
        end
        S_TX_WRITE: begin
          r_we    <= 1'b1;
          r_addr  <= tx_ctrl ? ADDR_CTRL : ADDR_DATA;
          r_wdata <= {24'b0, tx_data};
        end
        default: begin
          r_we    <= 1'b0;
          r_addr  <= r_addr;
          r_wdata <= r_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_ctrl  <= 1'b0;
    end else if ((r_state == S_RX_READ) && wbm_ack_in) begin
      r_rx_valid <= 1'b1;
      r_rx_data  <= wbm_data_in[7:0];
      r_rx_ctrl  <= r_status[1];
    end else if ((r_state == S_RX_HOLD) && rx_ready) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign wbm_cyc_out  = w_cyc;
  assign wbm_stb_out  = w_cyc;
  assign wbm_we_out   = r_we;
  assign wbm_addr_out = r_addr;
  assign wbm_data_out = r_wdata;
  assign rx_valid     = r_rx_valid;
  assign rx_data      = r_rx_data;
  assign rx_ctrl      = r_rx_ctrl;
  assign tx_ready     = (r_state == S_TX_WRITE) && wbm_ack_in;
  assign bus_error    = r_bus_error;

endmodule

// File: tb/tb_zube_sched.sv
// Directed bench for zube_sched: a Wishbone slave model logs every acked transfer
// and the stimulus sequence compares the log and stream outputs with fixed values.
module tb_zube_sched;

  localparam logic [31:0] A_DATA = 32'h3000_0004;
  localparam logic [31:0] A_CTRL = 32'h3000_0008;
  localparam logic [31:0] A_STAT = 32'h3000_000C;

  logic        clk = 1'b0;
  logic        reset_b = 1'b1;
  logic        enable = 1'b0;
  logic        zube_irq = 1'b0;
  logic        wbm_cyc_out, wbm_stb_out, wbm_we_out;
  logic [31:0] wbm_addr_out, wbm_data_out;
  logic [31:0] wbm_data_in = '0;
  logic        wbm_ack_in = 1'b0;
  logic        rx_valid, rx_ctrl;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_ctrl = 1'b0;
  logic        tx_ready, bus_error;

  zube_sched dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .zube_irq(zube_irq),
    .wbm_cyc_out(wbm_cyc_out), .wbm_stb_out(wbm_stb_out), .wbm_we_out(wbm_we_out),
    .wbm_addr_out(wbm_addr_out), .wbm_data_out(wbm_data_out),
    .wbm_data_in(wbm_data_in), .wbm_ack_in(wbm_ack_in),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ctrl(rx_ctrl), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ctrl(tx_ctrl), .tx_ready(tx_ready),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Slave model state and transaction log
  logic [7:0]  status_val = '0, data_val = '0, ctrl_val = '0;
  int          ack_wait = 0;
  bit          ack_wr_en = 1'b1;
  int          s_run = 0;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic        q_we[$];
  int          q_cyc[$];

  // Monitor state
  int cycle = 0, txr_cnt = 0, txr_bad = 0, gap_viol = 0, cs_viol = 0, run = 0, last_run = 0;
  bit prev_ack = 1'b0;

  always @(negedge clk) begin
    if (wbm_cyc_out) s_run++;
    else             s_run = 0;
    if (wbm_cyc_out && wbm_stb_out && (s_run > ack_wait) && (!wbm_we_out || ack_wr_en)) begin
      wbm_ack_in = 1'b1;
      case (wbm_addr_out)
        A_STAT:  wbm_data_in = {24'hDEAD5A, status_val};
        A_DATA:  wbm_data_in = {24'hC0FFEE, data_val};
        A_CTRL:  wbm_data_in = {24'hBEEF00, ctrl_val};
        default: wbm_data_in = 32'hBAD0_00EE;
      endcase
      q_addr.push_back(wbm_addr_out);
      q_we.push_back(wbm_we_out);
      q_data.push_back(wbm_data_out);
      q_cyc.push_back(cycle);
    end else begin
      wbm_ack_in  = 1'b0;
      wbm_data_in = 32'h5555_5555;
    end
  end

  always @(posedge clk) begin
    cycle++;
    if (wbm_cyc_out !== wbm_stb_out) cs_viol++;
    if (prev_ack && wbm_cyc_out) gap_viol++;
    prev_ack = wbm_ack_in && wbm_cyc_out;
    if (tx_ready) begin
      txr_cnt++;
      if (!(wbm_ack_in && wbm_we_out && wbm_cyc_out)) txr_bad++;
    end
    if (wbm_cyc_out) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  end

  task automatic wait_log(input int n, input int budget, input string tag);
    int k = 0;
    while (q_addr.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(q_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input int budget, input string tag);
    int k = 0;
    while (!rx_valid && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic accept_rx();
    @(negedge clk); rx_ready = 1'b1;
    @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic pulse_irq();
    @(negedge clk); zube_irq = 1'b1;
    @(negedge clk); zube_irq = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
  endtask

  task automatic check_txn(input string tag, input int idx, input logic [31:0] addr,
                           input logic we, input logic [31:0] data);
    if (idx < q_addr.size()) begin
      check({tag, "_addr"}, q_addr[idx], addr);
      check({tag, "_we"}, 32'(q_we[idx]), 32'(we));
      check({tag, "_data"}, q_data[idx], data);
    end else begin
      check({tag, "_missing"}, 32'(q_addr.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, t0, hold_bad;

    // Reset state
    #3 reset_b = 1'b0;
    #1;
    check("rst_cyc_stb", {30'b0, wbm_cyc_out, wbm_stb_out}, 32'd0);
    check("rst_we", 32'(wbm_we_out), 32'd0);
    check("rst_addr", wbm_addr_out, 32'd0);
    check("rst_wdata", wbm_data_out, 32'd0);
    check("rst_rx", {22'b0, rx_valid, rx_data, rx_ctrl}, 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;

    // Disabled: an irq is remembered but causes no bus traffic
    pulse_irq();
    repeat (20) @(negedge clk);
    check("disabled_no_bus", 32'(q_addr.size()), 32'd0);

    // STATUS 0x01: status read, DATA read, rx byte 0x5A, hold, then re-poll
    status_val = 8'h01; data_val = 8'h5A;
    b = q_addr.size();
    enable = 1'b1;
    wait_rx(50, "t1_rx_wait");
    check_txn("t1_poll", b, A_STAT, 1'b0, 32'd0);
    check_txn("t1_rd", b + 1, A_DATA, 1'b0, 32'd0);
    if (q_cyc.size() > b + 1) check("t1_gap_cycles", 32'(q_cyc[b + 1] - q_cyc[b]), 32'd2);
    check("t1_rx_data", 32'(rx_data), 32'h5A);
    check("t1_rx_ctrl", 32'(rx_ctrl), 32'd0);
    status_val = 8'h00;
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rx_valid !== 1'b1 || rx_data !== 8'h5A || wbm_cyc_out !== 1'b0) hold_bad++;
    end
    check("t1_hold_stable", 32'(hold_bad), 32'd0);
    check("t1_hold_no_bus", 32'(q_addr.size()), 32'(b + 2));
    accept_rx();
    check("t1_rx_cleared", 32'(rx_valid), 32'd0);
    wait_log(b + 3, 20, "t1_repoll_wait");
    check_txn("t1_repoll", b + 2, A_STAT, 1'b0, 32'd0);
    repeat (5) @(negedge clk);

    // STATUS 0x03: CONTROL first, DATA only after a re-poll
    status_val = 8'h03; ctrl_val = 8'h3C; data_val = 8'h5A;
    b = q_addr.size();
    pulse_irq();
    wait_rx(50, "t2_rx1_wait");
    check_txn("t2_poll1", b, A_STAT, 1'b0, 32'd0);
    check_txn("t2_rd_ctrl", b + 1, A_CTRL, 1'b0, 32'd0);
    check("t2_rx1", {23'b0, rx_data, rx_ctrl}, {23'b0, 8'h3C, 1'b1});
    status_val = 8'h01;
    accept_rx();
    wait_rx(50, "t2_rx2_wait");
    check_txn("t2_poll2", b + 2, A_STAT, 1'b0, 32'd0);
    check_txn("t2_rd_data", b + 3, A_DATA, 1'b0, 32'd0);
    check("t2_rx2", {23'b0, rx_data, rx_ctrl}, {23'b0, 8'h5A, 1'b0});
    status_val = 8'h00;
    accept_rx();
    repeat (5) @(negedge clk);

    // TX to DATA with STATUS 0x00; tx_ready only in the ack cycle
    b = q_addr.size(); t0 = txr_cnt;
    tx_data = 8'hA5; tx_ctrl = 1'b0; tx_valid = 1'b1;
    for (int k = 0; k < 50 && !tx_ready; k++) begin
      @(negedge clk); #1;
    end
    check("t3_tx_ready_seen", 32'(tx_ready), 32'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_log(b + 3, 20, "t3_wait");
    check_txn("t3_poll", b, A_STAT, 1'b0, 32'd0);
    check_txn("t3_write", b + 1, A_DATA, 1'b1, 32'h0000_00A5);
    check_txn("t3_repoll", b + 2, A_STAT, 1'b0, 32'd0);
    check("t3_tx_ready_count", 32'(txr_cnt - t0), 32'd1);
    repeat (3) @(negedge clk);

    // STATUS 0x40: DATA full, no write; next poll after 1000 idle cycles
    status_val = 8'h40;
    b = q_addr.size(); t0 = txr_cnt;
    tx_valid = 1'b1;
    wait_log(b + 2, 1200, "t3b_wait");
    check_txn("t3b_poll1", b, A_STAT, 1'b0, 32'd0);
    check_txn("t3b_poll2", b + 1, A_STAT, 1'b0, 32'd0);
    // POLL ack, one DECIDE, 1000 IDLE cycles, then the next POLL ack
    if (q_cyc.size() > b + 1) check("t3b_poll_interval", 32'(q_cyc[b + 1] - q_cyc[b]), 32'd1002);
    check("t3b_no_tx_ready", 32'(txr_cnt - t0), 32'd0);
    tx_valid = 1'b0; status_val = 8'h00;

    // Persistent STATUS 0x01 with tx_valid held: rx, tx, rx, tx
    do_reset();
    status_val = 8'h01; data_val = 8'h11;
    tx_data = 8'h77; tx_ctrl = 1'b0; rx_ready = 1'b1;
    b = q_addr.size(); t0 = txr_cnt;
    tx_valid = 1'b1;
    wait_log(b + 8, 200, "t4_wait");
    @(posedge clk); #1;
    tx_valid = 1'b0; status_val = 8'h00; rx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)      check_txn($sformatf("t4_poll%0d", i), b + i, A_STAT, 1'b0, 32'd0);
      else if (i % 4 == 1) check_txn($sformatf("t4_rx%0d", i), b + i, A_DATA, 1'b0, 32'd0);
      else                 check_txn($sformatf("t4_tx%0d", i), b + i, A_DATA, 1'b1, 32'h77);
    end
    check("t4_tx_ready_count", 32'(txr_cnt - t0), 32'd2);
    repeat (5) @(negedge clk);

    // Ack in the final timeout cycle is still a success
    ack_wait = 63;
    status_val = 8'h01; data_val = 8'h42;
    b = q_addr.size();
    pulse_irq();
    wait_rx(300, "t5_rx_wait");
    repeat (2) @(negedge clk);
    check("t5_no_bus_error", 32'(bus_error), 32'd0);
    check("t5_rx_data", 32'(rx_data), 32'h42);
    check("t5_cyc_len", 32'(last_run), 32'd64);
    ack_wait = 0; status_val = 8'h00;
    accept_rx();
    repeat (5) @(negedge clk);

    // Write never acked: cyc drops after 64 cycles, bus_error sticks
    ack_wr_en = 1'b0;
    b = q_addr.size(); t0 = txr_cnt;
    tx_data = 8'hC3; tx_valid = 1'b1;
    for (int k = 0; k < 200 && !bus_error; k++) begin
      @(negedge clk); #1;
    end
    check("t6_bus_error_set", 32'(bus_error), 32'd1);
    tx_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_cyc_dropped", 32'(wbm_cyc_out), 32'd0);
    check("t6_timeout_len", 32'(last_run), 32'd64);
    check("t6_no_tx_ready", 32'(txr_cnt - t0), 32'd0);
    check("t6_only_poll_acked", 32'(q_addr.size()), 32'(b + 1));
    ack_wr_en = 1'b1;
    repeat (3) @(negedge clk);
    status_val = 8'h01; data_val = 8'h99;
    b = q_addr.size();
    pulse_irq();
    wait_rx(50, "t6_rx_wait");
    check_txn("t6_poll", b, A_STAT, 1'b0, 32'd0);
    check_txn("t6_rd", b + 1, A_DATA, 1'b0, 32'd0);
    check("t6_rx_data", 32'(rx_data), 32'h99);
    check("t6_bus_error_sticky", 32'(bus_error), 32'd1);
    status_val = 8'h00;
    accept_rx();
    repeat (5) @(negedge clk);

    // Reset during RX_HOLD clears rx_valid at once; first access afterwards is STATUS
    status_val = 8'h01; data_val = 8'h66;
    pulse_irq();
    wait_rx(50, "t7_rx_wait");
    status_val = 8'h00;
    @(negedge clk); #2;
    reset_b = 1'b0;
    #1;
    check("t7_rx_valid_async", 32'(rx_valid), 32'd0);
    check("t7_cyc_async", 32'(wbm_cyc_out), 32'd0);
    check("t7_bus_error_cleared", 32'(bus_error), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    b = q_addr.size();
    pulse_irq();
    wait_log(b + 1, 30, "t7_wait");
    check_txn("t7_first_after_reset", b, A_STAT, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    check("t7_rx_idle", 32'(rx_valid), 32'd0);

    // Protocol invariants across the whole run
    check("cyc_eq_stb", 32'(cs_viol), 32'd0);
    check("idle_after_ack", 32'(gap_viol), 32'd0);
    check("tx_ready_only_on_write_ack", 32'(txr_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
